lif_neuron_unit: RTL and testbench

Parallel leaky integrate-and-fire array that sits directly downstream of the event controller. It consumes the controller's stream of pre-synaptic spike addresses for one time step. For each address it fetches a weight row from external synaptic memory and adds it into every neuron's membrane potential. At end of step it applies leak and threshold, then presents the post-synaptic spike vector back to the controller over a valid/ack handshake.

---
 rtl/snn_pkg.sv | 36 +++
 rtl/lif_neuron.sv | 58 +++++
 rtl/lif_neuron_unit.sv | 92 +++++++++
 tb/tb_lif_neuron_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared types, default widths and saturating add for the LIF unit
//
// Purpose: common definitions for lif_neuron_unit and lif_neuron.
//   - DEF_* localparams: default widths, firing threshold and leak shift.
//   - lif_state_t: step controller states (ACCUM, DRAIN, ACTIV, DONE).
//   - sat_add: signed add clamped to a w-bit two's complement range.
package snn_pkg;

  localparam int DEF_NEURON_CNT = 32;
  localparam int DEF_ADDR_W     = 5;
  localparam int DEF_W_W        = 8;
  localparam int DEF_MEM_W      = 16;
  localparam int DEF_THRESH     = 64;
  localparam int DEF_LEAK_SHIFT = 3;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    ACTIV = 2'd2,
    DONE  = 2'd3
  } lif_state_t;

  // Operands are already sign-extended into int; valid for w up to 31.
  function automatic int sat_add(input int a, input int b, input int w);
    int lo;
    int hi;
    int s;
    lo = -(1 <<< (w - 1));
    hi = (1 <<< (w - 1)) - 1;
    s  = a + b;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/lif_neuron.sv
// rtl/lif_neuron.sv - one leaky integrate-and-fire neuron
//
// Purpose: holds one membrane potential, saturating-accumulates weights and
// applies leak/threshold/fire when the step is activated.
// Build option: LIF_SOFT_RESET_EN selects subtractive reset (v = vl - THRESH)
// on fire; otherwise a firing neuron is cleared to 0.
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   acc_en     add weight into v this cycle
//   weight     signed weight for this neuron
//   fire_en    apply leak and post-fire update this cycle
//   spike      combinational fire decision on the leaked potential
module lif_neuron
  import snn_pkg::*;
#(
  parameter int W_W        = DEF_W_W,
  parameter int MEM_W      = DEF_MEM_W,
  parameter int THRESH     = DEF_THRESH,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 acc_en,
  input  logic signed [W_W-1:0] weight,
  input  logic                 fire_en,
  output logic                 spike
);

  localparam logic signed [MEM_W-1:0] THRESH_V = MEM_W'(THRESH);

  logic signed [MEM_W-1:0] v;
  logic signed [MEM_W-1:0] v_acc;
  logic signed [MEM_W-1:0] vl;
  logic signed [MEM_W-1:0] v_fired;

  always_comb begin
    v_acc = MEM_W'(sat_add(int'(v), int'(weight), MEM_W));
    // Subtracting a right-shifted copy never overflows, even at the negative rail.
    vl    = v - (v >>> LEAK_SHIFT);
    spike = (vl >= THRESH_V);
`ifdef LIF_SOFT_RESET_EN
    v_fired = vl - THRESH_V;
`else
    v_fired = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v <= '0;
    end else if (acc_en) begin
      v <= v_acc;
    end else if (fire_en) begin
      v <= spike ? v_fired : vl;
    end
  end

endmodule

// File: rtl/lif_neuron_unit.sv
// rtl/lif_neuron_unit.sv - parallel LIF array with per-step spike handshake
//
// Purpose: accepts pre-synaptic spike addresses for one time step, fetches a
// weight row per address and accumulates it into every neuron, then leaks,
// fires and presents the post-synaptic spike vector until acknowledged.
// Build option: LIF_SOFT_RESET_EN (subtractive reset on fire, see lif_neuron).
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   spk_valid/spk_addr/spk_last   address stream in; spk_ready accepts
//   w_rd_en/w_rd_addr             weight-row read; w_data returns next cycle
//   post_synp_avail/neuron_spk_out/spk_ack   step result handshake
//   ts_cnt                        completed time steps (wraps)
module lif_neuron_unit
  import snn_pkg::*;
#(
  parameter int NEURON_CNT = DEF_NEURON_CNT,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int W_W        = DEF_W_W,
  parameter int MEM_W      = DEF_MEM_W,
  parameter int THRESH     = DEF_THRESH,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      spk_valid,
  input  logic [ADDR_W-1:0]         spk_addr,
  input  logic                      spk_last,
  output logic                      spk_ready,
  output logic                      w_rd_en,
  output logic [ADDR_W-1:0]         w_rd_addr,
  input  logic [NEURON_CNT*W_W-1:0] w_data,
  output logic                      post_synp_avail,
  output logic [NEURON_CNT-1:0]     neuron_spk_out,
  input  logic                      spk_ack,
  output logic [7:0]                ts_cnt
);

  lif_state_t state;
  lif_state_t state_next;
  logic       acc_pend;   // weight row for last cycle's read is on w_data now
  logic       fire_en;
  logic [NEURON_CNT-1:0] spike_next;

  always_comb begin
    spk_ready       = (state == ACCUM);
    post_synp_avail = (state == DONE);
    w_rd_en         = spk_ready && spk_valid;
    w_rd_addr       = spk_addr;
    fire_en         = (state == ACTIV);
    state_next      = state;
    case (state)
      ACCUM:   if (spk_last) state_next = DRAIN;
      DRAIN:   state_next = ACTIV;
      ACTIV:   state_next = DONE;
      DONE:    if (spk_ack) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ACCUM;
      acc_pend       <= 1'b0;
      neuron_spk_out <= '0;
      ts_cnt         <= 8'd0;
    end else begin
      state    <= state_next;
      acc_pend <= w_rd_en;
      if (fire_en) begin
        neuron_spk_out <= spike_next;
        ts_cnt         <= ts_cnt + 8'd1;
      end
    end
  end

  for (genvar i = 0; i < NEURON_CNT; i++) begin : g_neuron
    lif_neuron #(
      .W_W       (W_W),
      .MEM_W     (MEM_W),
      .THRESH    (THRESH),
      .LEAK_SHIFT(LEAK_SHIFT)
    ) u_neuron (
      .clk    (clk),
      .rst    (rst),
      .acc_en (acc_pend),
      .weight (w_data[i*W_W +: W_W]),
      .fire_en(fire_en),
      .spike  (spike_next[i])
    );
  end

endmodule

// File: tb/tb_lif_neuron_unit.sv
// tb/tb_lif_neuron_unit.sv - scoreboard testbench for lif_neuron_unit
module tb_lif_neuron_unit;

  localparam int N  = 32;
  localparam int AW = 5;
  localparam int WW = 8;
  localparam int MW = 16;
`ifdef LIF_SOFT_RESET_EN
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          spk_valid = 1'b0;
  logic [AW-1:0] spk_addr = '0;
  logic          spk_last = 1'b0;
  logic          spk_ack = 1'b0;
  logic          spk_ready;
  logic          w_rd_en;
  logic [AW-1:0] w_rd_addr;
  logic [N*WW-1:0] w_data;
  logic          post_synp_avail;
  logic [N-1:0]  neuron_spk_out;
  logic [7:0]    ts_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [N-1:0] spk;
    logic [7:0]   ts;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [7:0] exp_ts = 8'd0;
  logic avail_q = 1'b0;

  always #5 clk = ~clk;

  lif_neuron_unit dut (
    .clk            (clk),
    .rst            (rst),
    .spk_valid      (spk_valid),
    .spk_addr       (spk_addr),
    .spk_last       (spk_last),
    .spk_ready      (spk_ready),
    .w_rd_en        (w_rd_en),
    .w_rd_addr      (w_rd_addr),
    .w_data         (w_data),
    .post_synp_avail(post_synp_avail),
    .neuron_spk_out (neuron_spk_out),
    .spk_ack        (spk_ack),
    .ts_cnt         (ts_cnt)
  );

  wire signed [MW-1:0] v0  = dut.g_neuron[0].u_neuron.v;
  wire signed [MW-1:0] v18 = dut.g_neuron[18].u_neuron.v;
  wire signed [MW-1:0] v19 = dut.g_neuron[19].u_neuron.v;
  wire signed [MW-1:0] v31 = dut.g_neuron[31].u_neuron.v;

  function automatic logic [N*WW-1:0] row(input logic [AW-1:0] a);
    logic [N*WW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      case (a)
        5'd3:    r[i*WW +: WW] = 8'd20;
        5'd5:    r[i*WW +: WW] = 8'd45;
        5'd7:    r[i*WW +: WW] = 8'd64;
        5'd9:    r[i*WW +: WW] = 8'd127;
        5'd10:   r[i*WW +: WW] = 8'h80;
        5'd12:   r[i*WW +: WW] = 8'(4 * i);
        default: r[i*WW +: WW] = 8'd0;
      endcase
    end
    return r;
  endfunction

  // Synaptic memory: one-cycle read latency; junk when not reading.
  always @(posedge clk) w_data <= w_rd_en ? row(w_rd_addr) : {N{8'h05}};

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      avail_q = 1'b0;
    end else begin
      if (post_synp_avail && !avail_q) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL monitor: unexpected post_synp_avail, expected none");
        end else begin
          mon_e = exp_q.pop_front();
          chk("mon_spike_vec", neuron_spk_out, mon_e.spk);
          chk("mon_ts_cnt", ts_cnt, mon_e.ts);
        end
      end
      avail_q = post_synp_avail;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_v0", v0, 0);
    chk("rst_ts_cnt", ts_cnt, 0);
    chk("rst_avail", post_synp_avail, 0);
    chk("rst_spk_out", neuron_spk_out, 0);
    exp_ts = 8'd0;
    exp_q.delete();
    cyc();
    rst = 1'b1;
    cyc();
    chk("rst_ready", spk_ready, 1);
    chk("rst_v0_held", v0, 0);
  endtask

  task automatic run_step(input logic [AW-1:0] a, input int n, input bit merge,
                          input logic signed [MW-1:0] pre_v, input logic [N-1:0] spk,
                          input int hold);
    exp_ts = exp_ts + 8'd1;
    exp_q.push_back('{spk: spk, ts: exp_ts});
    for (int k = 0; k < n; k++) begin
      spk_valid = 1'b1;
      spk_addr  = a;
      spk_last  = merge && (k == n - 1);
      #1;
      if (k == 0) begin
        chk("acc_ready", spk_ready, 1);
        chk("acc_w_rd_en", w_rd_en, 1);
        chk("acc_w_rd_addr", w_rd_addr, a);
      end
      cyc();
    end
    spk_valid = 1'b0;
    spk_last  = 1'b0;
    if (!merge) begin
      spk_last = 1'b1;
      cyc();
      spk_last = 1'b0;
    end
    chk("drain_avail", post_synp_avail, 0);
    chk("drain_ready", spk_ready, 0);
    cyc();
    chk("activ_avail", post_synp_avail, 0);
    chk("pre_leak_v0", v0, pre_v);
    cyc();
    chk("done_avail_t3", post_synp_avail, 1);
    for (int k = 0; k < hold; k++) begin
      spk_valid = 1'b1;
      spk_last  = 1'b1;
      spk_addr  = 5'd3;
      #1;
      chk("hold_ready", spk_ready, 0);
      chk("hold_w_rd_en", w_rd_en, 0);
      chk("hold_avail", post_synp_avail, 1);
      chk("hold_spk_out", neuron_spk_out, spk);
      cyc();
    end
    spk_valid = 1'b0;
    spk_last  = 1'b0;
    spk_ack   = 1'b1;
    cyc();
    spk_ack = 1'b0;
    chk("ack_avail", post_synp_avail, 0);
    chk("ack_ready", spk_ready, 1);
  endtask

  initial begin
    cyc();
    cyc();
    chk("por_v0", v0, 0);
    chk("por_ts_cnt", ts_cnt, 0);
    chk("por_avail", post_synp_avail, 0);
    chk("por_spk_out", neuron_spk_out, 0);
    chk("por_w_rd_en", w_rd_en, 0);
    rst = 1'b1;
    cyc();
    chk("por_ready", spk_ready, 1);

    // 4 x 20 = 80, vl = 70, all fire; DONE held 10 cycles under stray input
    run_step(5'd3, 4, 1'b0, 16'sd80, {N{1'b1}}, 10);
    chk("fire_v0_after", v0, SOFT ? 6 : 0);
    chk("fire_v31_after", v31, SOFT ? 6 : 0);

    // valid+last together: 64 (or 70 with residue) accumulated before leak
    run_step(5'd7, 1, 1'b1, SOFT ? 16'sd70 : 16'sd64, '0, 0);
    chk("merge_v0_after", v0, SOFT ? 62 : 56);

    // reset with a read in flight
    spk_valid = 1'b1;
    spk_addr  = 5'd3;
    cyc();
    cyc();
    spk_valid = 1'b0;
    do_reset();

    // from power-up: 45 -> vl 40, then an empty step 40 -> 35
    run_step(5'd5, 1, 1'b0, 16'sd45, '0, 0);
    chk("step45_v0_after", v0, 40);
    run_step(5'd0, 0, 1'b0, 16'sd40, '0, 0);
    chk("empty_v0_after", v0, 35);

    // per-neuron slicing: weight 4*i, neurons 19..31 cross threshold
    do_reset();
    run_step(5'd12, 1, 1'b0, 16'sd0, 32'hFFF8_0000, 0);
    chk("slice_v18_after", v18, 63);
    chk("slice_v19_after", v19, SOFT ? 3 : 0);
    chk("slice_v31_after", v31, SOFT ? 45 : 0);

    // positive saturation
    do_reset();
    run_step(5'd9, 300, 1'b0, 16'sd32767, {N{1'b1}}, 0);
    chk("satp_v0_after", v0, SOFT ? 28608 : 0);

    // negative saturation
    do_reset();
    run_step(5'd10, 300, 1'b0, -16'sd32768, '0, 0);
    chk("satn_v0_after", v0, -28672);

    cyc();
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
